// File: rtl/dsi_lanes_scheduler.sv
// Power sequencing for the DSI lane controller and arbitration of its single
// write port between the video and command packet sources.
module dsi_lanes_scheduler #(
    parameter int READY_TIMEOUT    = 1024,
    parameter int CLK_SETUP_CYCLES = 10,
    parameter int CLK_PRE_CYCLES   = 40,
    parameter int GAP_CYCLES       = 8,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        ctrl_enable,
    input  logic        vid_req,
    input  logic [31:0] vid_data,
    input  logic [3:0]  vid_strb,
    input  logic        vid_last,
    input  logic        cmd_req,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_strb,
    input  logic        cmd_last,
    output logic        vid_grant,
    output logic        cmd_grant,
    output logic        vid_data_rqst,
    output logic        cmd_data_rqst,
    output logic        lines_enable,
    output logic        clock_enable,
    input  logic        lines_ready,
    input  logic        clock_ready,
    input  logic        iface_data_rqst,
    output logic [31:0] iface_write_data,
    output logic [3:0]  iface_write_strb,
    output logic        iface_write_rqst,
    output logic        iface_last_word,
    output logic        link_up,
    output logic        fault,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_OFF, S_LANES_UP, S_CLK_SETUP, S_CLK_UP, S_PRE, S_IDLE,
        S_GRANT, S_XFER, S_GAP, S_CLK_DOWN, S_LANES_DOWN, S_FAULT
    } state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CMD} owner_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(READY_TIMEOUT - 1);
    localparam logic [15:0] SETUP_LAST   = 16'(CLK_SETUP_CYCLES - 1);
    localparam logic [15:0] PRE_LAST     = 16'(CLK_PRE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] STARVE_CMP   = 16'(STARVE_LIMIT);

    state_t      state;
    owner_t      owner;
    logic [15:0] cnt;
    logic [15:0] starve_cnt;

    logic [31:0] own_data;
    logic [3:0]  own_strb;
    logic        own_last;
    logic        cmd_wins;

    always_comb begin
        own_data = '0;
        own_strb = '0;
        own_last = 1'b0;
        case (owner)
            OWN_VID: begin
                own_data = vid_data;
                own_strb = vid_strb;
                own_last = vid_last;
            end
            OWN_CMD: begin
                own_data = cmd_data;
                own_strb = cmd_strb;
                own_last = cmd_last;
            end
            default: ;
        endcase
    end

    assign cmd_wins = cmd_req && (!vid_req || (starve_cnt >= STARVE_CMP));

    // cnt restarts from zero on every state entry; it serves both as the
    // ready timeout and as the setup/pre/gap delay counter.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_OFF;
            owner        <= OWN_NONE;
            cnt          <= '0;
            starve_cnt   <= '0;
            lines_enable <= 1'b0;
            clock_enable <= 1'b0;
            fault        <= 1'b0;
        end else begin
            cnt <= cnt + 16'd1;
            case (state)
                S_OFF: begin
                    if (ctrl_enable) begin
                        lines_enable <= 1'b1;
                        state        <= S_LANES_UP;
                        cnt          <= '0;
                    end
                end
                S_LANES_UP: begin
                    if (lines_ready) begin
                        state <= S_CLK_SETUP;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        fault        <= 1'b1;
                        lines_enable <= 1'b0;
                        clock_enable <= 1'b0;
                        state        <= S_FAULT;
                        cnt          <= '0;
                    end
                end
                S_CLK_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        clock_enable <= 1'b1;
                        state        <= S_CLK_UP;
                        cnt          <= '0;
                    end
                end
                S_CLK_UP: begin
                    if (clock_ready) begin
                        state <= S_PRE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        fault        <= 1'b1;
                        lines_enable <= 1'b0;
                        clock_enable <= 1'b0;
                        state        <= S_FAULT;
                        cnt          <= '0;
                    end
                end
                S_PRE: begin
                    if (cnt == PRE_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                S_IDLE: begin
                    if (!ctrl_enable) begin
                        clock_enable <= 1'b0;
                        state        <= S_CLK_DOWN;
                        cnt          <= '0;
                    end else if (cmd_wins) begin
                        owner <= OWN_CMD;
                        state <= S_GRANT;
                        cnt   <= '0;
                    end else if (vid_req) begin
                        owner <= OWN_VID;
                        state <= S_GRANT;
                        cnt   <= '0;
                    end
                end
                S_GRANT: begin
                    if (owner == OWN_VID) begin
                        if (starve_cnt != 16'hFFFF) starve_cnt <= starve_cnt + 16'd1;
                    end else begin
                        starve_cnt <= '0;
                    end
                    state <= own_last ? S_GAP : S_XFER;
                    cnt   <= '0;
                end
                S_XFER: begin
                    if (iface_data_rqst && own_last) begin
                        state <= S_GAP;
                        cnt   <= '0;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        owner <= OWN_NONE;
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                S_CLK_DOWN: begin
                    if (!clock_ready || (cnt == TIMEOUT_LAST)) begin
                        lines_enable <= 1'b0;
                        state        <= S_LANES_DOWN;
                        cnt          <= '0;
                    end
                end
                S_LANES_DOWN: begin
                    if (!lines_ready) begin
                        state <= S_OFF;
                        cnt   <= '0;
                    end
                end
                S_FAULT: begin
                    if (!ctrl_enable) begin
                        fault <= 1'b0;
                        state <= S_OFF;
                        cnt   <= '0;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

    // Handshake: a word moves from the owner to the lane controller in the
    // GRANT cycle (grant pulse, first word) and in every XFER cycle where
    // iface_data_rqst is high (mirrored to the owner's data_rqst).
    always_comb begin
        iface_write_rqst = 1'b0;
        iface_write_data = '0;
        iface_write_strb = '0;
        iface_last_word  = 1'b0;
        vid_grant        = 1'b0;
        cmd_grant        = 1'b0;
        vid_data_rqst    = 1'b0;
        cmd_data_rqst    = 1'b0;
        case (state)
            S_GRANT: begin
                iface_write_rqst = 1'b1;
                iface_write_data = own_data;
                iface_write_strb = own_strb;
                iface_last_word  = own_last;
                vid_grant        = (owner == OWN_VID);
                cmd_grant        = (owner == OWN_CMD);
            end
            S_XFER: begin
                iface_write_data = own_data;
                iface_write_strb = own_strb;
                iface_last_word  = own_last;
                vid_data_rqst    = (owner == OWN_VID) && iface_data_rqst;
                cmd_data_rqst    = (owner == OWN_CMD) && iface_data_rqst;
            end
            default: ;
        endcase
    end

    assign link_up   = (state == S_IDLE) || (state == S_GRANT) ||
                       (state == S_XFER) || (state == S_GAP);
    assign state_dbg = state;

endmodule

// File: tb/tb_dsi_lanes_scheduler.sv
// Directed bench for dsi_lanes_scheduler: power sequencing, arbitration,
// packet transfer, timeout, shutdown and reset, with a word scoreboard.
module tb_dsi_lanes_scheduler;

    localparam int W = 40;  // {rqst, vid, cmd, last, strb[3:0], data[31:0]}

    logic        clk_sys, rst_n, ctrl_enable;
    logic        vid_req, vid_last, cmd_req, cmd_last;
    logic [31:0] vid_data, cmd_data;
    logic [3:0]  vid_strb, cmd_strb;
    logic        vid_grant, cmd_grant, vid_data_rqst, cmd_data_rqst;
    logic        lines_enable, clock_enable, lines_ready, clock_ready, iface_data_rqst;
    logic [31:0] iface_write_data;
    logic [3:0]  iface_write_strb;
    logic        iface_write_rqst, iface_last_word, link_up, fault;
    logic [3:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic       dr_en = 1'b1;
    logic [3:0] dr_pat = 4'b0110;
    logic       src_abort = 1'b0;

    int n, s_edge, f1, l1, f2, l2;
    logic seen;

    dsi_lanes_scheduler dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .ctrl_enable(ctrl_enable),
        .vid_req(vid_req), .vid_data(vid_data), .vid_strb(vid_strb), .vid_last(vid_last),
        .cmd_req(cmd_req), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_last(cmd_last),
        .vid_grant(vid_grant), .cmd_grant(cmd_grant),
        .vid_data_rqst(vid_data_rqst), .cmd_data_rqst(cmd_data_rqst),
        .lines_enable(lines_enable), .clock_enable(clock_enable),
        .lines_ready(lines_ready), .clock_ready(clock_ready), .iface_data_rqst(iface_data_rqst),
        .iface_write_data(iface_write_data), .iface_write_strb(iface_write_strb),
        .iface_write_rqst(iface_write_rqst), .iface_last_word(iface_last_word),
        .link_up(link_up), .fault(fault), .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // lane controller read-side pacing
    initial begin
        iface_data_rqst = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            iface_data_rqst = dr_en && dr_pat[cyc % 4];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic void push_exp(input bit first, input bit is_cmd, input bit last,
                                     input logic [3:0] strb, input logic [31:0] data);
        exp_q.push_back({first, !is_cmd, is_cmd, last, strb, data});
    endfunction

    // driver: presents npkt packets of nw words; word w of packet p is base+p*16+w
    task automatic run_src(input bit is_cmd, input int npkt, input int nw,
                           input logic [31:0] base, output int first_cyc, output int last_cyc);
        logic hit;
        int   k;
        first_cyc = -1;
        last_cyc  = -1;
        for (int p = 0; p < npkt; p++) begin
            for (int w = 0; w < nw; w++) begin
                if (is_cmd) begin
                    cmd_req  = (w == 0);
                    cmd_data = base + 32'(p * 16 + w);
                    cmd_strb = (w == nw - 1) ? 4'h3 : 4'hF;
                    cmd_last = (w == nw - 1);
                end else begin
                    vid_req  = (w == 0);
                    vid_data = base + 32'(p * 16 + w);
                    vid_strb = (w == nw - 1) ? 4'h3 : 4'hF;
                    vid_last = (w == nw - 1);
                end
                hit = 1'b0;
                k = 0;
                while (!hit && !src_abort && k < 3000) begin
                    @(negedge clk_sys);
                    hit = is_cmd ? (cmd_grant || cmd_data_rqst) : (vid_grant || vid_data_rqst);
                    k++;
                end
                if (src_abort) return;
                if (!hit) begin
                    chk(is_cmd ? "cmd_src_timeout" : "vid_src_timeout", 64'(hit), 64'd1);
                    return;
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                tick();
            end
        end
        if (is_cmd) begin
            cmd_req = 0; cmd_last = 0; cmd_data = '0; cmd_strb = '0;
        end else begin
            vid_req = 0; vid_last = 0; vid_data = '0; vid_strb = '0;
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] act, exp;
        forever begin
            @(negedge clk_sys);
            if (rst_n === 1'b1 && (iface_write_rqst || vid_data_rqst || cmd_data_rqst)) begin
                act = {iface_write_rqst, vid_grant | vid_data_rqst, cmd_grant | cmd_data_rqst,
                       iface_last_word, iface_write_strb, iface_write_data};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", act);
                end else begin
                    exp = exp_q.pop_front();
                    chk("xfer_word", 64'(act), 64'(exp));
                end
            end
        end
    end

    task automatic power_up();
        int k, lr_edge, cr_edge;
        ctrl_enable = 1'b1;
        k = 0;
        while (!lines_enable && k < 10) begin tick(); k++; end
        chk("lines_enable_up", 64'(lines_enable), 64'd1);
        repeat (4) tick();
        lines_ready = 1'b1;
        lr_edge = cyc + 1;
        k = 0;
        while (!clock_enable && k < 50) begin tick(); k++; end
        chk("clk_setup_delay", 64'(cyc - lr_edge), 64'd10);
        repeat (2) tick();
        clock_ready = 1'b1;
        cr_edge = cyc + 1;
        k = 0;
        while (!link_up && k < 100) begin tick(); k++; end
        chk("clk_pre_delay", 64'(cyc - cr_edge), 64'd40);
    endtask

    initial begin
        rst_n = 1'b0; ctrl_enable = 1'b0;
        vid_req = 0; vid_data = '0; vid_strb = '0; vid_last = 0;
        cmd_req = 0; cmd_data = '0; cmd_strb = '0; cmd_last = 0;
        lines_ready = 0; clock_ready = 0;
        repeat (3) tick();
        chk("rst_write_rqst", 64'(iface_write_rqst), 64'd0);
        chk("rst_grants", 64'({vid_grant, cmd_grant}), 64'd0);
        chk("rst_enables", 64'({lines_enable, clock_enable}), 64'd0);
        chk("rst_link_fault", 64'({link_up, fault}), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        rst_n = 1'b1;
        tick();

        power_up();

        // arbitration: both requesting continuously -> V,V,V,V,C,V,V,V,V,C
        for (int i = 0, v = 0, c = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                push_exp(1, 1, 1, 4'h3, 32'hC000_0000 + 32'(c * 16)); c++;
            end else begin
                push_exp(1, 0, 1, 4'h3, 32'hB000_0000 + 32'(v * 16)); v++;
            end
        end
        fork
            run_src(0, 8, 1, 32'hB000_0000, f1, l1);
            run_src(1, 2, 1, 32'hC000_0000, f2, l2);
        join

        // three-word video packet, then gap spacing to the next grant
        push_exp(1, 0, 0, 4'hF, 32'hA0A0_0000);
        push_exp(0, 0, 0, 4'hF, 32'hA0A0_0001);
        push_exp(0, 0, 1, 4'h3, 32'hA0A0_0002);
        run_src(0, 1, 3, 32'hA0A0_0000, f1, l1);
        push_exp(1, 0, 1, 4'h3, 32'h5555_0000);
        run_src(0, 1, 1, 32'h5555_0000, f2, l2);
        // last data_rqst cycle, 8 gap cycles, one idle cycle, then grant
        chk("gap_to_next_grant", 64'(f2 - l1), 64'd10);

        // shutdown during a command packet
        push_exp(1, 1, 0, 4'hF, 32'hDD00_0000);
        push_exp(0, 1, 0, 4'hF, 32'hDD00_0001);
        push_exp(0, 1, 1, 4'h3, 32'hDD00_0002);
        fork
            run_src(1, 1, 3, 32'hDD00_0000, f1, l1);
            begin
                n = 0;
                while (!cmd_grant && n < 100) begin @(negedge clk_sys); n++; end
                tick();
                chk("in_xfer_at_disable", 64'(state_dbg), 64'd7);
                ctrl_enable = 1'b0;
                tick(); tick();
                chk("clk_held_during_pkt", 64'(clock_enable), 64'd1);
            end
        join
        n = 0;
        while (clock_enable && n < 30) begin tick(); n++; end
        chk("clk_enable_down", 64'(clock_enable), 64'd0);
        repeat (3) tick();
        chk("lines_held_clk_ready", 64'(lines_enable), 64'd1);
        clock_ready = 1'b0;
        n = 0;
        while (lines_enable && n < 5) begin tick(); n++; end
        chk("lines_enable_down", 64'(lines_enable), 64'd0);
        lines_ready = 1'b0;
        tick(); tick();
        chk("shutdown_off", 64'({state_dbg, link_up}), 64'd0);

        // lines_ready timeout -> fault
        ctrl_enable = 1'b1;
        n = 0;
        while (!lines_enable && n < 10) begin tick(); n++; end
        s_edge = cyc;
        n = 0;
        while (!fault && n < 1100) begin tick(); n++; end
        chk("timeout_cycles", 64'(cyc - s_edge), 64'd1024);
        chk("fault_enables", 64'({fault, lines_enable, clock_enable}), 64'b100);
        ctrl_enable = 1'b0;
        tick();
        chk("fault_cleared", 64'({fault, state_dbg}), 64'd0);

        // reset in the middle of a stalled video packet
        power_up();
        dr_en = 1'b0;
        push_exp(1, 0, 0, 4'hF, 32'hEE00_0000);
        fork
            run_src(0, 1, 3, 32'hEE00_0000, f1, l1);
            begin
                n = 0;
                while (!vid_grant && n < 100) begin @(negedge clk_sys); n++; end
                tick(); tick();
                #2 rst_n = 1'b0;
                #1;
                chk("rst_mid_rqst_grant", 64'({iface_write_rqst, vid_grant, vid_data_rqst}), 64'd0);
                chk("rst_mid_enables", 64'({lines_enable, clock_enable, link_up}), 64'd0);
                chk("rst_mid_data", 64'(iface_write_data), 64'd0);
                src_abort = 1'b1;
            end
        join
        vid_req = 1'b1; vid_data = 32'h7700_0000; vid_strb = 4'h3; vid_last = 1'b1;
        lines_ready = 1'b0; clock_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_sys);
            if (vid_grant || cmd_grant || iface_write_rqst) seen = 1'b1;
        end
        chk("no_grant_before_powerup", 64'(seen), 64'd0);
        chk("repower_started", 64'({lines_enable, link_up}), 64'b10);
        vid_req = 1'b0;
        src_abort = 1'b0;
        dr_en = 1'b1;
        tick();
        power_up();
        push_exp(1, 0, 1, 4'h3, 32'h7700_0000);
        run_src(0, 1, 1, 32'h7700_0000, f1, l1);

        repeat (20) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsi_lanes_scheduler.md
Name: dsi_lanes_scheduler

Overview:
- Sequences power-up and power-down of the DSI lane controller: data lanes first, then clock lane, and the reverse on shutdown.
- Arbitrates the controller's single write interface between two packet sources: video stream (vid_*) and command/DCS (cmd_*).
- Sits between the packet assembler and dsi_lanes_controller, in the clk_sys domain.

Parameters:
- READY_TIMEOUT, 1024: max clk_sys cycles to wait for lines_ready or clock_ready before entering FAULT.
- CLK_SETUP_CYCLES, 10: cycles between lines_ready and clock_enable assertion.
- CLK_PRE_CYCLES, 40: cycles after clock_ready before the first grant.
- GAP_CYCLES, 8: idle cycles enforced between packets.
- STARVE_LIMIT, 4: consecutive video grants after which a pending command wins.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  async active-low reset
- ctrl_enable  in  1  level; 1 = bring link up, 0 = take link down
- vid_req / cmd_req  in  1 each  packet pending; first word valid while high
- vid_data / cmd_data  in  32 each  word
- vid_strb / cmd_strb  in  4 each  byte strobes
- vid_last / cmd_last  in  1 each  current word is final
- vid_grant / cmd_grant  out  1 each  one-cycle pulse: first word taken
- vid_data_rqst / cmd_data_rqst  out  1 each  next word requested
- lines_enable, clock_enable  out  1 each  to lane controller
- lines_ready, clock_ready, iface_data_rqst  in  1 each  from lane controller
- iface_write_data  out  32
- iface_write_strb  out  4
- iface_write_rqst  out  1
- iface_last_word  out  1
- link_up  out  1  state is IDLE, GRANT, XFER or GAP
- fault  out  1  sticky until ctrl_enable=0

Behaviour:
- Reset: all outputs 0; state OFF; counters 0; starve counter 0; owner=none.
- OFF: on ctrl_enable=1, set lines_enable=1 and go to LANES_UP.
- LANES_UP: on lines_ready=1, go to CLK_SETUP. On timeout (READY_TIMEOUT cycles), go to FAULT.
- CLK_SETUP: count CLK_SETUP_CYCLES, then set clock_enable=1 and go to CLK_UP.
- CLK_UP: on clock_ready=1, go to PRE. On timeout, go to FAULT.
- PRE: count CLK_PRE_CYCLES, then go to IDLE.
- IDLE: if ctrl_enable=0, go to CLK_DOWN.
  - Otherwise pick a winner:
    - cmd wins if cmd_req=1 and (vid_req=0 or starve counter >= STARVE_LIMIT);
    - else vid wins if vid_req=1.
  - Latch the owner, then go to GRANT.
- GRANT (1 cycle):
  - Drive iface_write_rqst=1 with the owner's data/strb/last; pulse <owner>_grant.
  - Video grant increments the starve counter (saturating); command grant clears it.
  - If owner last=1, go to GAP; else go to XFER.
- XFER:
  - iface_write_data/strb/last_word mux the owner's inputs combinationally.
  - <owner>_data_rqst = iface_data_rqst; the non-owner's data_rqst stays 0.
  - On a cycle with iface_data_rqst=1 and owner last=1, go to GAP.
  - ctrl_enable=0 does not abort a packet.
- GAP:
  - Outputs to the lane controller return to 0.
  - Count GAP_CYCLES, clear the owner, go to IDLE.
- CLK_DOWN: clock_enable=0. When clock_ready=0 (or on timeout), set lines_enable=0 and go to LANES_DOWN.
- LANES_DOWN: when lines_ready=0, go to OFF.
- FAULT:
  - fault=1, lines_enable=0, clock_enable=0.
  - On ctrl_enable=0, clear fault and go to OFF.
- Requests are ignored outside IDLE; grants never issue unless link_up=1.
- Simultaneous vid_req and cmd_req with counter < STARVE_LIMIT: video wins.
- iface_write_rqst is asserted only in GRANT.
- Counters: 16 bit. The timeout counter resets on each state entry.
- Async reset mid-packet: all outputs 0 immediately; the packet is dropped.

Test Plan:
- Power-up: ctrl_enable=1, lines_ready at +5 cycles, clock_ready at +3 after clock_enable → clock_enable rises exactly 10 cycles after lines_ready; link_up rises 40 cycles after clock_ready.
- Single 3-word video packet:
  - vid_req with words A,B,C → one iface_write_rqst pulse carrying A.
  - vid_data_rqst mirrors iface_data_rqst.
  - GAP entered after the data_rqst cycle in which C (last=1) is presented; next grant no earlier than 8 cycles later.
- Arbitration: vid_req and cmd_req held high continuously → grant order V,V,V,V,C,V,V,V,V,C.
- Timeout: lines_ready held 0 → fault=1 after 1024 cycles with lines_enable=0; ctrl_enable=0 clears fault and returns to OFF.
- Shutdown mid-packet: ctrl_enable=0 during XFER → packet completes, then clock_enable falls, lines_enable falls once clock_ready=0, state reaches OFF.
- Reset during XFER: rst_n=0 → iface_write_rqst, grants, enables all 0 in the same cycle; no grant until a full re-power-up.
